// File: rtl/pc_ras.sv
// Fetch-stage program counter with a circular return-address stack, stall hold
// and exception redirect with EPC capture.
module pc_ras #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] START_ADDR = '0,
  parameter int               INC        = 4,
  parameter logic [31:0]      EXC_VECTOR = 32'h80000180,
  parameter int               DEPTH      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch,
  input  logic [WIDTH-1:0] boff,
  input  logic             jump,
  input  logic             call,
  input  logic [WIDTH-1:0] jaddr,
  input  logic             ret,
  input  logic [WIDTH-1:0] ra_in,
  input  logic             exc,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] EXC_W = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  // Stack pointer arithmetic wraps at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
    return (p == '0) ? PW'(DEPTH - 1) : p - PW'(1);
  endfunction

  logic        [WIDTH-1:0] pc_p1, epc_p1;
  logic        [WIDTH-1:0] pc_p0, epc_p0;
  logic        [WIDTH-1:0] seq_pc_p0;
  logic signed [WIDTH-1:0] boff_s;
  logic        [WIDTH-1:0] stack [DEPTH];
  logic        [PW-1:0]    top_p1, top_p0, top_up;
  logic        [CW-1:0]    cnt_p1, cnt_p0;
  logic                    push_p0, uf_p0;

  assign boff_s    = boff;
  assign seq_pc_p0 = pc_p1 + INC_W;
  assign top_up    = ptr_inc(top_p1);

  // Stage p0: next-state selection in priority order.
  always_comb begin
    pc_p0   = pc_p1;
    epc_p0  = epc_p1;
    cnt_p0  = cnt_p1;
    top_p0  = top_p1;
    push_p0 = 1'b0;
    uf_p0   = 1'b0;
    if (exc) begin
      pc_p0  = EXC_W;
      epc_p0 = pc_p1;
      cnt_p0 = '0;
    end else if (stall) begin
      pc_p0 = pc_p1;
    end else if (ret) begin
      if (cnt_p1 != '0) begin
        pc_p0  = stack[top_p1];
        cnt_p0 = cnt_p1 - CW'(1);
        top_p0 = ptr_dec(top_p1);
      end else begin
        pc_p0 = ra_in;
        uf_p0 = 1'b1;
      end
    end else if (call) begin
      pc_p0   = jaddr;
      push_p0 = 1'b1;
      top_p0  = top_up;
      // A full stack overwrites its oldest slot, so the count saturates.
      cnt_p0  = (cnt_p1 == CW'(DEPTH)) ? cnt_p1 : cnt_p1 + CW'(1);
    end else if (jump) begin
      pc_p0 = jaddr;
    end else if (branch) begin
      pc_p0 = WIDTH'($signed(seq_pc_p0) + boff_s);
    end else begin
      pc_p0 = seq_pc_p0;
    end
  end

  // Stage p1: architectural state and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p1         <= START_ADDR;
      epc_p1        <= '0;
      cnt_p1        <= '0;
      top_p1        <= '0;
      ras_empty     <= 1'b1;
      ras_full      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc_p1         <= pc_p0;
      epc_p1        <= epc_p0;
      cnt_p1        <= cnt_p0;
      top_p1        <= top_p0;
      ras_empty     <= (cnt_p0 == '0);
      ras_full      <= (cnt_p0 == CW'(DEPTH));
      ras_underflow <= uf_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_p0) stack[top_up] <= seq_pc_p0;
  end

  assign pc_out = pc_p1;
  assign epc    = epc_p1;

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed scenarios then random traffic, compared each cycle
// against a queue-based reference model of the return-address stack.
module tb_pc_ras;

  localparam logic [31:0] START = 32'h100;
  localparam logic [31:0] EXCV  = 32'h80000180;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, stall, branch, jump, call, ret, exc;
  logic [31:0] boff, jaddr, ra_in;
  logic [31:0] pc_out, epc;
  logic        ras_empty, ras_full, ras_underflow;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_uf;
  logic [31:0] m_q [$];

  always #5 clk = ~clk;

  pc_ras #(.WIDTH(32), .START_ADDR(START), .INC(4), .EXC_VECTOR(EXCV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch(branch), .boff(boff),
    .jump(jump), .call(call), .jaddr(jaddr), .ret(ret), .ra_in(ra_in),
    .exc(exc), .pc_out(pc_out), .epc(epc), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_underflow(ras_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: stack as a queue, newest at the back, oldest dropped past DEPTH.
  task automatic model_step();
    if (rst) begin
      m_pc = START; m_epc = 0; m_q.delete(); m_uf = 0;
    end else if (exc) begin
      m_epc = m_pc; m_pc = EXCV; m_q.delete(); m_uf = 0;
    end else if (stall) begin
      m_uf = 0;
    end else if (ret) begin
      if (m_q.size() > 0) begin
        m_pc = m_q.pop_back(); m_uf = 0;
      end else begin
        m_pc = ra_in; m_uf = 1;
      end
    end else if (call) begin
      m_q.push_back(m_pc + 32'd4);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      m_pc = jaddr; m_uf = 0;
    end else if (jump) begin
      m_pc = jaddr; m_uf = 0;
    end else if (branch) begin
      m_pc = m_pc + 32'd4 + boff; m_uf = 0;
    end else begin
      m_pc = m_pc + 32'd4; m_uf = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] bo,
                     input logic j, input logic c, input logic [31:0] ja,
                     input logic rt, input logic [31:0] ra, input logic e);
    rst = r; stall = s; branch = b; boff = bo; jump = j; call = c;
    jaddr = ja; ret = rt; ra_in = ra; exc = e;
    @(posedge clk);
    model_step();
    #1;
    chk("pc_out", pc_out, m_pc);
    chk("epc", epc, m_epc);
    chk("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
    chk("ras_full", 32'(ras_full), 32'(m_q.size() == DEPTH));
    chk("ras_underflow", 32'(ras_underflow), 32'(m_uf));
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic jmp(input logic [31:0] a);
    cyc(0, 0, 0, 0, 1, 0, a, 0, 0, 0);
  endtask

  initial begin
    int r;
    logic [31:0] ra_exp [5];
    m_pc = 0; m_epc = 0; m_uf = 0;

    // Reset and free run, then a reset that overrides a call in flight.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", pc_out, 32'h100);
    idle(); chk("seq1", pc_out, 32'h104);
    idle(); chk("seq2", pc_out, 32'h108);
    idle(); chk("seq3", pc_out, 32'h10C);
    cyc(1, 0, 0, 0, 0, 1, 32'h700, 0, 0, 0);
    chk("mid_reset", pc_out, 32'h100);
    chk("mid_reset_empty", 32'(ras_empty), 32'd1);

    // Negative branch, then stall with lower-priority controls asserted.
    jmp(32'h1FC);
    cyc(0, 0, 1, -32'sd8, 0, 0, 0, 0, 0, 0);
    chk("branch_neg", pc_out, 32'h1F8);
    jmp(32'h200);
    cyc(0, 0, 1, -32'sd8, 0, 0, 0, 0, 0, 0);
    chk("branch_200", pc_out, 32'h1FC);
    cyc(0, 1, 0, 0, 0, 1, 32'h900, 1, 0, 0);
    cyc(0, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("stall_hold", pc_out, 32'h1FC);
    chk("stall_no_push", 32'(ras_empty), 32'd1);

    // Call and return.
    jmp(32'h10);
    cyc(0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0);
    chk("call_tgt", pc_out, 32'h400);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("ret_addr", pc_out, 32'h14);
    chk("ret_empty", 32'(ras_empty), 32'd1);

    // Five nested calls overflow a four-deep stack; fifth ret underflows.
    for (int i = 0; i < 5; i++) begin
      ra_exp[i] = pc_out + 32'd4;
      cyc(0, 0, 0, 0, 0, 1, 32'h1000 * (i + 1), 0, 0, 0);
    end
    chk("nest_full", 32'(ras_full), 32'd1);
    for (int i = 4; i >= 1; i--) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("nest_ret", pc_out, ra_exp[i]);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hABC, 0);
    chk("uf_pc", pc_out, 32'hABC);
    chk("uf_pulse", 32'(ras_underflow), 32'd1);
    idle();
    chk("uf_clear", 32'(ras_underflow), 32'd0);

    // Exception beats a simultaneous call.
    cyc(0, 0, 0, 0, 0, 1, 32'h600, 0, 0, 0);
    jmp(32'h300);
    cyc(0, 0, 0, 0, 0, 1, 32'h500, 0, 0, 1);
    chk("exc_pc", pc_out, 32'h80000180);
    chk("exc_epc", epc, 32'h300);
    chk("exc_flush", 32'(ras_empty), 32'd1);

    // Address wrap, then ret beats call.
    jmp(32'hFFFFFFFC);
    idle();
    chk("wrap", pc_out, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 32'h500, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h800, 1, 0, 0);
    chk("ret_wins", pc_out, 32'h4);
    chk("ret_wins_nopush", 32'(ras_empty), 32'd1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      cyc(r < 1, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
          32'(signed'(32'($urandom_range(0, 255)) - 32'd128)) & ~32'd3,
          $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0,
          $urandom() & ~32'd3, $urandom_range(0, 3) == 0, $urandom(),
          $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
